fetch_sequencer: RTL and testbench
==================================

// Module: fetch_sequencer
// PURPOSE
//  Sequences instruction fetch for the IF stage. It owns the fetch PC and issues one
//  req/ack transaction at a time to a variable-latency instruction memory. It holds the
//  fetched instruction steady for the IF/ID register while the hazard unit asserts freeze,
//  and it redirects and flushes on branch_taken, including when a request is in flight.
// PARAMETERS
//  ADDR_W    32   fetch address / PC width
//  DATA_W    32   instruction width
//  RESET_PC  0    first fetch address after reset
//  PC_STEP   4    PC increment per accepted instruction
// PORTS
//  clk           in   1       rising-edge clock
//  rst           in   1       asynchronous reset, active-high
//  freeze        in   1       hazard stall; hold the output instruction, issue no new request
//  branch_taken  in   1       redirect pulse from EXE; flushes the fetch
//  branch_addr   in   ADDR_W  redirect target, sampled when branch_taken=1
//  mem_req       out  1       instruction-memory request
//  mem_addr      out  ADDR_W  request address; stable while mem_req=1 and mem_ack=0
//  mem_ack       in   1       response valid; meaningful only while mem_req=1
//  mem_rdata     in   DATA_W  instruction data, valid with mem_ack
//  if_valid      out  1       if_instr/if_pc hold a live instruction
//  if_pc         out  ADDR_W  fetched address + PC_STEP (next-PC convention)
//  if_instr      out  DATA_W  fetched instruction
// BEHAVIOUR
//  Reset (async):
//   - state=IDLE, pc_q=RESET_PC, req_addr_q=0, buf_q=0.
//   - if_valid=0, if_pc=0, if_instr=0, mem_req=0.
//  States:
//   - IDLE: no request outstanding.
//   - WAIT: request outstanding.
//   - DRAIN: request outstanding, result will be discarded.
//   - FULL: response buffered while freeze=1.
//  Outputs:
//   - mem_req=1 in WAIT and DRAIN; 0 in IDLE and FULL.
//   - mem_addr=req_addr_q, registered at issue.
//  Priority: branch_taken > mem_ack > freeze.
//  IDLE:
//   - branch_taken: pc_q<=branch_addr; if_valid<=0; stay IDLE.
//   - else if !freeze: req_addr_q<=pc_q; go to WAIT. mem_req rises the next cycle.
//   - else stay.
//  WAIT:
//   - branch_taken & mem_ack: discard rdata; pc_q<=branch_addr; if_valid<=0; go to IDLE.
//   - branch_taken & !mem_ack: pc_q<=branch_addr; if_valid<=0; go to DRAIN.
//   - mem_ack & !freeze: if_instr<=rdata; if_pc<=req_addr_q+PC_STEP; if_valid<=1;
//     pc_q<=pc_q+PC_STEP; go to IDLE.
//   - mem_ack & freeze: buf_q<=rdata; pc_q<=pc_q+PC_STEP; go to FULL. Outputs hold.
//  DRAIN:
//   - mem_ack: discard rdata; go to IDLE.
//   - branch_taken: pc_q<=newest branch_addr; last redirect wins.
//  FULL:
//   - branch_taken: drop buf_q; pc_q<=branch_addr; if_valid<=0; go to IDLE.
//   - !freeze: if_instr<=buf_q; if_pc<=req_addr_q+PC_STEP; if_valid<=1; go to IDLE.
//  Freeze and if_valid:
//   - freeze=1 holds if_valid/if_pc/if_instr unchanged, except on a branch flush.
//   - When freeze=0 and no new instruction is delivered that cycle, if_valid<=0, so an
//     instruction is presented for exactly one unfrozen cycle.
//  Throughput and latency:
//   - Best-case throughput is one instruction per 2 cycles (IDLE->WAIT->IDLE).
//   - Latency from issue is mem latency + 1 cycle.
//  Arithmetic: PC adds are modulo 2^ADDR_W. The fetch after 0xFFFFFFFC is 0x00000000.
//  Reset mid-transaction: the outstanding request is abandoned and mem_req drops
//   immediately. Memory must tolerate a dropped request.
// CONFIGURATION
//  FETCH_PERF_CNT_EN defined:
//   - Adds out ports perf_fetched[31:0] and perf_flushed[31:0], both reset to 0 and
//     wrapping at 2^32.
//   - perf_fetched counts each delivery into if_instr.
//   - perf_flushed counts each branch_taken cycle that discards an in-flight request, a
//     buffered response, or a valid output.
//  FETCH_PERF_CNT_EN undefined: the ports and counters are absent and behaviour is
//   otherwise identical.
// TESTING
//  1. Reset; 0-wait ack (mem_ack=1 same cycle as mem_req), rdata=addr^0xA5A5A5A5
//     -> mem_addr 0,4,8 on successive requests; if_pc 4,8,12; if_valid pulses every 2nd cycle.
//  2. 3-cycle memory latency; freeze=1 raised in WAIT for 5 cycles -> FULL entered;
//     if_* unchanged; the instruction is delivered the cycle after freeze falls.
//  3. branch_taken with branch_addr=0x100 in WAIT, ack 2 cycles later
//     -> rdata discarded, if_valid=0, next mem_addr=0x100.
//  4. branch_taken and mem_ack in the same cycle, branch_addr=0x40 -> no delivery;
//     next request is 0x40. Repeat the branch in DRAIN with 0x80 -> next request is 0x80.
//  5. RESET_PC=0xFFFFFFFC -> second request mem_addr=0x0; if_pc of the first instruction=0x0.
//  6. Assert rst while mem_req=1 -> mem_req=0 and all outputs 0 asynchronously; first new
//     request goes to RESET_PC. With FETCH_PERF_CNT_EN, check both counters after tests 3-4.

Source files
------------

// File: rtl/fetch_sequencer.sv
// IF-stage fetch sequencer: owns the fetch PC and runs one req/ack transaction at a time.
// Optional performance counters are enabled by defining FETCH_PERF_CNT_EN.
module fetch_sequencer #(
  parameter int unsigned        ADDR_W   = 32,
  parameter int unsigned        DATA_W   = 32,
  parameter logic [ADDR_W-1:0]  RESET_PC = '0,
  parameter int unsigned        PC_STEP  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              freeze,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_addr,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              if_valid,
  output logic [ADDR_W-1:0] if_pc,
  output logic [DATA_W-1:0] if_instr
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]       perf_fetched,
  output logic [31:0]       perf_flushed
`endif
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_DRAIN = 2'd2,
    S_FULL  = 2'd3
  } state_e;

  localparam logic [ADDR_W-1:0] STEP = ADDR_W'(PC_STEP);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] req_addr_q, req_addr_d;
  logic [DATA_W-1:0] buf_q, buf_d;
  logic              mem_req_q, mem_req_d;
  logic              if_valid_q, if_valid_d;
  logic [ADDR_W-1:0] if_pc_q, if_pc_d;
  logic [DATA_W-1:0] if_instr_q, if_instr_d;
  logic              deliver;
  logic              flush;

  always_comb begin
    // NOTE: every signal gets a default before the case so no path infers a latch.
    state_d    = state_q;
    pc_d       = pc_q;
    req_addr_d = req_addr_q;
    buf_d      = buf_q;
    if_valid_d = freeze ? if_valid_q : 1'b0;
    if_pc_d    = if_pc_q;
    if_instr_d = if_instr_q;
    deliver    = 1'b0;
    flush      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (branch_taken) begin
          pc_d       = branch_addr;
          if_valid_d = 1'b0;
          flush      = if_valid_q;
        end else if (!freeze) begin
          req_addr_d = pc_q;
          state_d    = S_WAIT;
        end
      end
      S_WAIT: begin
        if (branch_taken) begin
          pc_d       = branch_addr;
          if_valid_d = 1'b0;
          flush      = 1'b1;
          state_d    = mem_ack ? S_IDLE : S_DRAIN;
        end else if (mem_ack) begin
          pc_d = pc_q + STEP;
          if (!freeze) begin
            if_instr_d = mem_rdata;
            if_pc_d    = req_addr_q + STEP;
            if_valid_d = 1'b1;
            deliver    = 1'b1;
            state_d    = S_IDLE;
          end else begin
            buf_d   = mem_rdata;
            state_d = S_FULL;
          end
        end
      end
      S_DRAIN: begin
        // The request is still owed an ack; only the redirect target may change meanwhile.
        if (branch_taken) begin
          pc_d       = branch_addr;
          if_valid_d = 1'b0;
          flush      = 1'b1;
        end
        if (mem_ack) begin
          state_d = S_IDLE;
        end
      end
      S_FULL: begin
        if (branch_taken) begin
          pc_d       = branch_addr;
          if_valid_d = 1'b0;
          flush      = 1'b1;
          state_d    = S_IDLE;
        end else if (!freeze) begin
          if_instr_d = buf_q;
          if_pc_d    = req_addr_q + STEP;
          if_valid_d = 1'b1;
          deliver    = 1'b1;
          state_d    = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    mem_req_d = (state_d == S_WAIT) || (state_d == S_DRAIN);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      pc_q       <= RESET_PC;
      req_addr_q <= '0;
      buf_q      <= '0;
      mem_req_q  <= 1'b0;
      if_valid_q <= 1'b0;
      if_pc_q    <= '0;
      if_instr_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge values.
      state_q    <= state_d;
      pc_q       <= pc_d;
      req_addr_q <= req_addr_d;
      buf_q      <= buf_d;
      mem_req_q  <= mem_req_d;
      if_valid_q <= if_valid_d;
      if_pc_q    <= if_pc_d;
      if_instr_q <= if_instr_d;
    end
  end

  assign mem_req  = mem_req_q;
  assign mem_addr = req_addr_q;
  assign if_valid = if_valid_q;
  assign if_pc    = if_pc_q;
  assign if_instr = if_instr_q;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetched_q, perf_fetched_d;
  logic [31:0] perf_flushed_q, perf_flushed_d;

  always_comb begin
    perf_fetched_d = perf_fetched_q + {31'd0, deliver};
    perf_flushed_d = perf_flushed_q + {31'd0, flush};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_fetched_q <= '0;
      perf_flushed_q <= '0;
    end else begin
      perf_fetched_q <= perf_fetched_d;
      perf_flushed_q <= perf_flushed_d;
    end
  end

  assign perf_fetched = perf_fetched_q;
  assign perf_flushed = perf_flushed_q;
`else
  logic unused_perf;
  assign unused_perf = deliver ^ flush;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: one task per scenario, inline comparisons.
// A second instance with RESET_PC=0xFFFFFFFC and an always-ready memory covers PC wrap.
`timescale 1ns/1ps
module tb_fetch_sequencer;
  localparam logic [31:0] KEY = 32'hA5A5A5A5;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        freeze = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_addr = '0;
  logic        mem_req, mem_ack;
  logic [31:0] mem_addr, mem_rdata;
  logic        if_valid;
  logic [31:0] if_pc, if_instr;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetched, perf_flushed;
  logic [31:0] perf_fetched2, perf_flushed2;
`endif

  logic        mem_req2, mem_ack2;
  logic [31:0] mem_addr2, mem_rdata2;
  logic        if_valid2;
  logic [31:0] if_pc2, if_instr2;

  // Memory model: auto mode acks after `lat` extra cycles of mem_req; manual mode uses man_ack.
  logic auto_mem = 1'b1;
  logic man_ack  = 1'b0;
  logic auto_ack = 1'b0;
  int   lat      = 0;
  int   wait_cnt = 0;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (mem_req) begin
      auto_ack = (wait_cnt == lat);
      wait_cnt = wait_cnt + 1;
    end else begin
      auto_ack = 1'b0;
      wait_cnt = 0;
    end
  end

  assign mem_ack    = auto_mem ? auto_ack : man_ack;
  assign mem_rdata  = mem_addr ^ KEY;
  assign mem_ack2   = mem_req2;
  assign mem_rdata2 = mem_addr2 ^ KEY;

  fetch_sequencer dut (
    .clk(clk), .rst(rst), .freeze(freeze), .branch_taken(branch_taken),
    .branch_addr(branch_addr), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .if_valid(if_valid),
    .if_pc(if_pc), .if_instr(if_instr)
`ifdef FETCH_PERF_CNT_EN
    , .perf_fetched(perf_fetched), .perf_flushed(perf_flushed)
`endif
  );

  fetch_sequencer #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clk(clk), .rst(rst), .freeze(freeze), .branch_taken(branch_taken),
    .branch_addr(branch_addr), .mem_req(mem_req2), .mem_addr(mem_addr2),
    .mem_ack(mem_ack2), .mem_rdata(mem_rdata2), .if_valid(if_valid2),
    .if_pc(if_pc2), .if_instr(if_instr2)
`ifdef FETCH_PERF_CNT_EN
    , .perf_fetched(perf_fetched2), .perf_flushed(perf_flushed2)
`endif
  );

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    freeze = 1'b0;
    branch_taken = 1'b0;
    branch_addr = '0;
    man_ack = 1'b0;
    auto_mem = 1'b1;
    lat = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_chk++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL reset_mem_req: got %b want 0", mem_req); end
    n_chk++; if (mem_addr !== 32'h0) begin n_fail++; $display("FAIL reset_mem_addr: got %h want 0", mem_addr); end
    n_chk++; if (if_valid !== 1'b0) begin n_fail++; $display("FAIL reset_if_valid: got %b want 0", if_valid); end
    n_chk++; if (if_pc !== 32'h0) begin n_fail++; $display("FAIL reset_if_pc: got %h want 0", if_pc); end
    n_chk++; if (if_instr !== 32'h0) begin n_fail++; $display("FAIL reset_if_instr: got %h want 0", if_instr); end
`ifdef FETCH_PERF_CNT_EN
    n_chk++; if (perf_fetched !== 32'h0) begin n_fail++; $display("FAIL reset_perf_fetched: got %0d want 0", perf_fetched); end
    n_chk++; if (perf_flushed !== 32'h0) begin n_fail++; $display("FAIL reset_perf_flushed: got %0d want 0", perf_flushed); end
`endif
  endtask

  // Zero-wait memory: a request every other cycle, one-cycle if_valid pulses.
  task automatic test_zero_wait();
    logic [31:0] exp_addr;
    do_reset();
    lat = 0;
    for (int i = 0; i < 3; i++) begin
      exp_addr = 32'(i * 4);
      step();
      n_chk++; if (mem_req !== 1'b1 || mem_addr !== exp_addr) begin n_fail++; $display("FAIL zw_req%0d: got req=%b addr=%h want req=1 addr=%h", i, mem_req, mem_addr, exp_addr); end
      n_chk++; if (if_valid !== 1'b0) begin n_fail++; $display("FAIL zw_gap%0d: got if_valid=%b want 0", i, if_valid); end
      step();
      n_chk++; if (if_valid !== 1'b1 || if_pc !== exp_addr + 32'd4 || if_instr !== (exp_addr ^ KEY)) begin
        n_fail++; $display("FAIL zw_deliver%0d: got v=%b pc=%h instr=%h want v=1 pc=%h instr=%h", i, if_valid, if_pc, if_instr, exp_addr + 32'd4, exp_addr ^ KEY);
      end
      n_chk++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL zw_req_low%0d: got %b want 0", i, mem_req); end
    end
  endtask

  // Freeze in IDLE holds the output; freeze in WAIT parks the response in FULL.
  task automatic test_freeze();
    do_reset();
    lat = 3;
    step(5);
    n_chk++; if (if_valid !== 1'b1 || if_pc !== 32'h4) begin n_fail++; $display("FAIL fz_first: got v=%b pc=%h want v=1 pc=00000004", if_valid, if_pc); end
    freeze = 1'b1;
    step(2);
    n_chk++; if (if_valid !== 1'b1 || if_pc !== 32'h4 || mem_req !== 1'b0) begin n_fail++; $display("FAIL fz_idle_hold: got v=%b pc=%h req=%b want v=1 pc=00000004 req=0", if_valid, if_pc, mem_req); end
    freeze = 1'b0;
    step();
    n_chk++; if (mem_req !== 1'b1 || mem_addr !== 32'h4 || if_valid !== 1'b0) begin n_fail++; $display("FAIL fz_issue: got req=%b addr=%h v=%b want req=1 addr=00000004 v=0", mem_req, mem_addr, if_valid); end
    freeze = 1'b1;
    step(4);
    n_chk++; if (mem_req !== 1'b0 || if_valid !== 1'b0 || if_pc !== 32'h4 || if_instr !== KEY) begin
      n_fail++; $display("FAIL fz_full: got req=%b v=%b pc=%h instr=%h want req=0 v=0 pc=00000004 instr=%h", mem_req, if_valid, if_pc, if_instr, KEY);
    end
    step();
    n_chk++; if (mem_req !== 1'b0 || if_valid !== 1'b0 || if_pc !== 32'h4) begin n_fail++; $display("FAIL fz_full_hold: got req=%b v=%b pc=%h want req=0 v=0 pc=00000004", mem_req, if_valid, if_pc); end
    freeze = 1'b0;
    step();
    n_chk++; if (if_valid !== 1'b1 || if_pc !== 32'h8 || if_instr !== 32'hA5A5A5A1) begin n_fail++; $display("FAIL fz_release: got v=%b pc=%h instr=%h want v=1 pc=00000008 instr=a5a5a5a1", if_valid, if_pc, if_instr); end
    step();
    n_chk++; if (if_valid !== 1'b0 || mem_addr !== 32'h8 || mem_req !== 1'b1) begin n_fail++; $display("FAIL fz_pulse: got v=%b addr=%h req=%b want v=0 addr=00000008 req=1", if_valid, mem_addr, mem_req); end
  endtask

  // Branch during WAIT without ack: DRAIN swallows the late response.
  task automatic test_branch_wait();
    do_reset();
    auto_mem = 1'b0;
    step();
    branch_taken = 1'b1;
    branch_addr = 32'h100;
    step();
    branch_taken = 1'b0;
    n_chk++; if (mem_req !== 1'b1 || if_valid !== 1'b0) begin n_fail++; $display("FAIL br_drain: got req=%b v=%b want req=1 v=0", mem_req, if_valid); end
    step();
    man_ack = 1'b1;
    step();
    man_ack = 1'b0;
    n_chk++; if (mem_req !== 1'b0 || if_valid !== 1'b0) begin n_fail++; $display("FAIL br_discard: got req=%b v=%b want req=0 v=0", mem_req, if_valid); end
    step();
    n_chk++; if (mem_req !== 1'b1 || mem_addr !== 32'h100) begin n_fail++; $display("FAIL br_redirect: got req=%b addr=%h want req=1 addr=00000100", mem_req, mem_addr); end
    man_ack = 1'b1;
    step();
    man_ack = 1'b0;
    n_chk++; if (if_valid !== 1'b1 || if_pc !== 32'h104 || if_instr !== 32'hA5A5A4A5) begin n_fail++; $display("FAIL br_deliver: got v=%b pc=%h instr=%h want v=1 pc=00000104 instr=a5a5a4a5", if_valid, if_pc, if_instr); end
  endtask

  // Branch coincident with ack, then repeated branches inside DRAIN; continues from the previous task.
  task automatic test_branch_ack();
    step();
    n_chk++; if (mem_addr !== 32'h104 || mem_req !== 1'b1) begin n_fail++; $display("FAIL ba_issue: got addr=%h req=%b want addr=00000104 req=1", mem_addr, mem_req); end
    branch_taken = 1'b1;
    branch_addr = 32'h40;
    man_ack = 1'b1;
    step();
    branch_taken = 1'b0;
    man_ack = 1'b0;
    n_chk++; if (if_valid !== 1'b0 || mem_req !== 1'b0) begin n_fail++; $display("FAIL ba_no_deliver: got v=%b req=%b want v=0 req=0", if_valid, mem_req); end
    step();
    n_chk++; if (mem_addr !== 32'h40 || mem_req !== 1'b1) begin n_fail++; $display("FAIL ba_redirect: got addr=%h req=%b want addr=00000040 req=1", mem_addr, mem_req); end
    branch_taken = 1'b1;
    branch_addr = 32'h60;
    step();
    branch_addr = 32'h80;
    step();
    branch_taken = 1'b0;
    man_ack = 1'b1;
    step();
    man_ack = 1'b0;
    n_chk++; if (if_valid !== 1'b0 || mem_req !== 1'b0) begin n_fail++; $display("FAIL ba_drain_done: got v=%b req=%b want v=0 req=0", if_valid, mem_req); end
    step();
    n_chk++; if (mem_addr !== 32'h80 || mem_req !== 1'b1) begin n_fail++; $display("FAIL ba_last_wins: got addr=%h req=%b want addr=00000080 req=1", mem_addr, mem_req); end
`ifdef FETCH_PERF_CNT_EN
    n_chk++; if (perf_fetched !== 32'd1) begin n_fail++; $display("FAIL perf_fetched: got %0d want 1", perf_fetched); end
    n_chk++; if (perf_flushed !== 32'd4) begin n_fail++; $display("FAIL perf_flushed: got %0d want 4", perf_flushed); end
`endif
  endtask

  task automatic test_wrap();
    do_reset();
    step();
    n_chk++; if (mem_req2 !== 1'b1 || mem_addr2 !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap_first: got req=%b addr=%h want req=1 addr=fffffffc", mem_req2, mem_addr2); end
    step();
    n_chk++; if (if_valid2 !== 1'b1 || if_pc2 !== 32'h0 || if_instr2 !== 32'h5A5A5A59) begin n_fail++; $display("FAIL wrap_pc: got v=%b pc=%h instr=%h want v=1 pc=00000000 instr=5a5a5a59", if_valid2, if_pc2, if_instr2); end
    step();
    n_chk++; if (mem_req2 !== 1'b1 || mem_addr2 !== 32'h0) begin n_fail++; $display("FAIL wrap_second: got req=%b addr=%h want req=1 addr=00000000", mem_req2, mem_addr2); end
  endtask

  task automatic test_reset_midflight();
    do_reset();
    lat = 0;
    step(3);
    n_chk++; if (mem_req !== 1'b1 || mem_addr !== 32'h4 || if_pc !== 32'h4) begin n_fail++; $display("FAIL rm_setup: got req=%b addr=%h pc=%h want req=1 addr=00000004 pc=00000004", mem_req, mem_addr, if_pc); end
    #2;
    rst = 1'b1;
    #1;
    n_chk++; if (mem_req !== 1'b0 || mem_addr !== 32'h0 || if_valid !== 1'b0 || if_pc !== 32'h0 || if_instr !== 32'h0) begin
      n_fail++; $display("FAIL rm_async: got req=%b addr=%h v=%b pc=%h instr=%h want all zero", mem_req, mem_addr, if_valid, if_pc, if_instr);
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    step();
    n_chk++; if (mem_req !== 1'b1 || mem_addr !== 32'h0) begin n_fail++; $display("FAIL rm_restart: got req=%b addr=%h want req=1 addr=00000000", mem_req, mem_addr); end
  endtask

  initial begin
    test_reset();
    test_zero_wait();
    test_freeze();
    test_branch_wait();
    test_branch_ack();
    test_wrap();
    test_reset_midflight();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
